// File: rtl/risc_v_core_pkg.sv
// Shared RV32I decode types: the decoded instruction record, the control bundle,
// and the ALU operand-select / ALU-op encodings used by the execute stage.
package risc_v_core_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [5:0] {
        NOP, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } instr_name_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm_I;
        logic [11:0] imm_S;
        logic [12:0] imm_B;
        logic [20:0] imm_J;
        logic [31:0] imm_U;
        instr_name_t instr_name;
    } instruction_t;

    typedef struct packed {
        logic       valid;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       jal;
        logic       jalr;
        logic [1:0] ALUOp;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [5:0] Branch;
    } controls_t;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU mnemonic from funct3; alt selects SUB/SRA (or SRAI) when funct7[5] is set.
    function automatic instr_name_t alu_name(input logic [2:0] f3, input logic alt,
                                             input logic imm);
        instr_name_t n;
        case (f3)
            3'b000:  n = imm ? ADDI  : (alt ? SUB : ADD);
            3'b001:  n = imm ? SLLI  : SLL;
            3'b010:  n = imm ? SLTI  : SLT;
            3'b011:  n = imm ? SLTIU : SLTU;
            3'b100:  n = imm ? XORI  : XOR;
            3'b101:  n = imm ? (alt ? SRAI : SRLI) : (alt ? SRA : SRL);
            3'b110:  n = imm ? ORI   : OR;
            default: n = imm ? ANDI  : AND;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: raw word in, decoded fields, controls and an
// illegal flag out. Illegal words come out as NOP with all controls cleared.
import risc_v_core_pkg::*;

module instr_decoder (
    input  logic [31:0]  instr,
    output instruction_t fields,
    output controls_t    ctrl,
    output logic         illegal
);
    logic [2:0]  f3;
    logic [6:0]  f7;
    instr_name_t name;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        name    = NOP;
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode_t'(instr[6:0]))
            OP_R: begin
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = ALUOP_R;
                ctrl.ALUSrcB  = SRCB_RS2;
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
                    name = alu_name(f3, f7[5], 1'b0);
                else
                    illegal = 1'b1;
            end
            OP_I: begin
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = ALUOP_I;
                ctrl.ALUSrcB  = SRCB_IMM;
                name          = alu_name(f3, f7[5], 1'b1);
                // Shift-immediates reuse the funct7 slot; only 0x00 (and 0x20 for SRAI) are legal.
                if (f3 == 3'b001 && f7 != 7'h00)
                    illegal = 1'b1;
                if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
                    illegal = 1'b1;
            end
            OP_LOAD: begin
                ctrl.MemRead  = 1'b1;
                ctrl.MemtoReg = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrcB  = SRCB_IMM;
                ctrl.ALUOp    = ALUOP_MEM;
                case (f3)
                    3'b000:  name = LB;
                    3'b001:  name = LH;
                    3'b010:  name = LW;
                    3'b100:  name = LBU;
                    3'b101:  name = LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                ctrl.MemWrite = 1'b1;
                ctrl.ALUSrcB  = SRCB_IMM;
                ctrl.ALUOp    = ALUOP_MEM;
                case (f3)
                    3'b000:  name = SB;
                    3'b001:  name = SH;
                    3'b010:  name = SW;
                    default: illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                ctrl.ALUOp = ALUOP_BR;
                case (f3)
                    3'b000:  begin name = BEQ;  ctrl.Branch = 6'b000001; end
                    3'b001:  begin name = BNE;  ctrl.Branch = 6'b000010; end
                    3'b100:  begin name = BLT;  ctrl.Branch = 6'b000100; end
                    3'b101:  begin name = BGE;  ctrl.Branch = 6'b001000; end
                    3'b110:  begin name = BLTU; ctrl.Branch = 6'b010000; end
                    3'b111:  begin name = BGEU; ctrl.Branch = 6'b100000; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                name          = JAL;
                ctrl.jal      = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrcA  = SRCA_PC;
                ctrl.ALUSrcB  = SRCB_FOUR;
            end
            OP_JALR: begin
                name          = JALR;
                ctrl.jalr     = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrcA  = SRCA_PC;
                ctrl.ALUSrcB  = SRCB_FOUR;
                illegal       = (f3 != 3'b000);
            end
            OP_LUI: begin
                name          = LUI;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrcA  = SRCA_ZERO;
                ctrl.ALUSrcB  = SRCB_IMM;
            end
            OP_AUIPC: begin
                name          = AUIPC;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrcA  = SRCA_PC;
                ctrl.ALUSrcB  = SRCB_IMM;
            end
            // The all-zero word is the canonical bubble, not a fault.
            default: illegal = (instr != 32'b0);
        endcase

        if (illegal) begin
            name = NOP;
            ctrl = '0;
        end else begin
            ctrl.valid = (instr != 32'b0);
        end

        fields.opcode     = instr[6:0];
        fields.funct3     = f3;
        fields.funct7     = f7;
        fields.rs1        = instr[19:15];
        fields.rs2        = instr[24:20];
        fields.rd         = instr[11:7];
        fields.imm_I      = instr[31:20];
        fields.imm_S      = {instr[31:25], instr[11:7]};
        fields.imm_B      = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fields.imm_J      = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fields.imm_U      = {instr[31:12], 12'b0};
        fields.instr_name = name;
    end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode FIFO that decodes each RV32I word on entry and flushes on redirect.
// Define DECODE_ILLEGAL_TRAP_EN to queue illegal words with an out_illegal flag.
import risc_v_core_pkg::*;

module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output instruction_t               out_instr,
    output controls_t                  out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                       out_illegal
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    instruction_t    mem_instr [DEPTH];
    controls_t       mem_ctrl  [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    instruction_t    dec_instr;
    controls_t       dec_ctrl;
    logic            dec_illegal;
    logic            push;
    logic            pop;

    instr_decoder u_dec (
        .instr   (in_instr),
        .fields  (dec_instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // in_ready depends only on occupancy, so fetch never sees out_ready combinationally.
    assign in_ready  = (count < CNT_FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic mem_ill [DEPTH];
    assign out_illegal = mem_ill[rd_ptr];
`else
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_ctrl[i]  <= '0;
                mem_pc[i]    <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                mem_ill[i]   <= 1'b0;
`endif
            end
        end else if (flush) begin
            // Redirect: only the pointers move; stale contents stay but are unreachable.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= dec_instr;
                mem_ctrl[wr_ptr]  <= dec_ctrl;
                mem_pc[wr_ptr]    <= in_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
                mem_ill[wr_ptr]   <= dec_illegal;
`endif
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    assign out_pc    = mem_pc[rd_ptr];
    assign out_instr = mem_instr[rd_ptr];
    assign out_ctrl  = mem_ctrl[rd_ptr];

endmodule

// File: doc/decode_queue.md
# decode_queue

- Parametrised fetch-to-decode buffer: accepts raw 32-bit RV32I instruction words with their PC through a valid/ready handshake, and decodes each one on entry.
- Decoding produces the shared `instruction_t` record and `controls_t` bundle, which are stored in a DEPTH-entry FIFO.
- Sits between the fetch stage and the ID/EX pipeline register, decoupling fetch stalls from execute back-pressure.
- Supports pipeline flush on branch/jump redirect.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `DEPTH`, 4, queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  discards all entries and any same-cycle push.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  queue can accept.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumer accepts the head.
- `out_pc`  out  XLEN  PC of the head entry.
- `out_instr`  out  `instruction_t`  decoded fields of the head entry.
- `out_ctrl`  out  `controls_t`  control bundle of the head entry.
- `count`  out  $clog2(DEPTH+1)  occupancy.
- `out_illegal`  out  1  head entry is illegal (only with `DECODE_ILLEGAL_TRAP_EN`).

## Operation
**Handshake**
- Push when `in_valid & in_ready`; pop when `out_valid & out_ready`.
- `in_ready = (count < DEPTH)`; it has no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- Push and pop in the same cycle leave `count` unchanged. This is legal at any `count` from 1 to DEPTH−1.
- Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- Push while full is ignored; fetch must hold its instruction.

**Flush**
- On the next edge: pointers = 0, `count` = 0.
- A same-cycle push is dropped; a same-cycle pop has no additional effect.
- `flush` outranks push and pop.
- `reset` outranks `flush`.

**Decode (combinational, before the storage write)**
- `opcode`, `funct3`, `funct7`, `rs1`, `rs2` and `rd` are extracted from their fixed bit positions.
- Immediates are stored raw at their declared widths: `imm_I`, `imm_S`, `imm_B` (bit 0 = 0), `imm_J` (bit 0 = 0), `imm_U` = {instr[31:12], 12'b0}.
- `instr_name` is resolved from opcode, funct3 and funct7[5].
- `ctrl.valid` = 1 for every legal instruction.
- R: `RegWrite`; `ALUOp` = 10; `ALUSrcB` = 00.
- I-ALU: `RegWrite`; `ALUSrcB` = 01; `ALUOp` = 11.
- Load: `MemRead`, `MemtoReg`, `RegWrite`; `ALUSrcB` = 01; `ALUOp` = 00.
- Store: `MemWrite`; `ALUSrcB` = 01; `ALUOp` = 00.
- Branch: `ALUOp` = 01; `Branch` is one-hot, mapping funct3 000/001/100/101/110/111 to bits 0–5 (BEQ..BGEU).
- JAL: `jal`, `RegWrite`; `ALUSrcA` = 01 (PC); `ALUSrcB` = 10 (constant 4).
- JALR: `jalr`, `RegWrite`; `ALUSrcA` = 01; `ALUSrcB` = 10.
- LUI: `RegWrite`; `ALUSrcA` = 10 (zero); `ALUSrcB` = 01.
- AUIPC: `RegWrite`; `ALUSrcA` = 01; `ALUSrcB` = 01.
- Illegal instructions are:
  - an unknown opcode;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 ≥ 011;
  - JALR funct3 ≠ 000;
  - R-type with funct7 other than 0x00/0x20, or 0x20 with funct3 not 000/101;
  - SLLI/SRLI/SRAI with a bad funct7.
- The all-zero word decodes to `NOP`: all controls 0 and not illegal.

## Timing
- Latency: an instruction pushed at edge N appears at the head at edge N if the queue was empty, i.e. `out_*` are valid in the cycle after the push. All outputs are registered storage reads.
- Throughput is one instruction per cycle.
- After reset: `count` = 0, `out_valid` = 0, `in_ready` = 1, `out_illegal` = 0.
- `out_pc`, `out_instr` and `out_ctrl` read entry 0, which reset clears to 0 (`NOP`, all controls 0).
- Storage contents are cleared on reset only; flush moves the pointers but does not clear contents.
- Reset asserted mid-stream discards everything on that edge; the inputs of that cycle are ignored.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - adds the `out_illegal` port and a 1-bit field per entry;
  - an illegal word stores `ctrl` all-zero, `instr_name` = `NOP`, `out_illegal` = 1;
  - it is still queued so a trap can be raised at its PC.
- Undefined:
  - no port and no field;
  - an illegal word is queued as `NOP` with all controls 0 (silently squashed).

## Structure
- `risc_v_core_pkg` holds:
  - `instruction_t`, `controls_t`, `opcode_t`, `instr_name_t`;
  - the new constants `ALUOP_MEM`=00, `ALUOP_BR`=01, `ALUOP_R`=10, `ALUOP_I`=11;
  - `SRCA_RS1`=00, `SRCA_PC`=01, `SRCA_ZERO`=10;
  - `SRCB_RS2`=00, `SRCB_IMM`=01, `SRCB_FOUR`=10.
- One sub-module, `instr_decoder`: purely combinational, raw word in, producing `instruction_t`, `controls_t` and the illegal flag. It is reused by any future multi-issue variant.
- The queue logic lives in `decode_queue`.

## Test plan
- Push ADD x3,x1,x2 (0x002081B3) into an empty queue → next cycle `out_valid`=1, `instr_name`=`ADD`, rd=3, rs1=1, rs2=2, `RegWrite`=1, `ALUOp`=10, `count`=1.
- Push BNE x1,x2,+8 (0x00209463) → `Branch`=6'b000010, `imm_B`=13'd8, `RegWrite`=0.
- DEPTH=4 with `out_ready`=0, 5 consecutive pushes → `in_ready`=0 after the 4th, `count`=4, the 5th is not accepted; draining yields PCs in push order.
- With `count`=2, push and pop in the same cycle for 10 cycles across pointer wrap → `count` stays 2 and output order matches input order.
- `flush` together with `in_valid` at `count`=3 → next cycle `count`=0, `out_valid`=0, the pushed word is absent; a push afterwards appears normally.
- 0xFFFFFFFF pushed with `DECODE_ILLEGAL_TRAP_EN` → `out_illegal`=1, `ctrl`=0. Without the macro → `NOP` with `ctrl`=0. Reset mid-stream → `count`=0 on the following cycle.
